// File: rtl/huc_pkg.sv
// Shared constants for the HuCard mapper family: CPU/memory address widths,
// well-known register addresses and a helper for low-bit masks.
package huc_pkg;

  localparam int HUC_CPU_AW = 21;
  localparam int HUC_MEM_AW = 24;

  localparam logic [HUC_CPU_AW-1:0] HUC_BRAM_PAGE = 21'h1EE000;
  localparam logic [HUC_CPU_AW-1:0] HUC_BRAM_UNLK = 21'h1FF807;
  localparam logic [HUC_CPU_AW-1:0] HUC_BRAM_LOCK = 21'h1FF803;
  localparam logic [12:0]           HUC_SF2_REG   = 13'h1FF0;

  function automatic logic [HUC_MEM_AW-1:0] huc_low_mask(input int aw);
    return HUC_MEM_AW'((25'd1 << aw) - 25'd1);
  endfunction

endpackage

// File: rtl/huc_map_ext_if.sv
// CPU bus plus cart memory bus seen by the mapper; master drives the CPU
// side and returns memory data, slave is the mapper itself.
interface huc_map_ext_if;
  import huc_pkg::*;

  logic [HUC_CPU_AW-1:0] cpu_addr;
  logic [7:0]            cpu_data;
  logic                  cpu_oe;
  logic                  cpu_we;
  logic [7:0]            rom_dato;
  logic [7:0]            ram_dato;

  logic [HUC_MEM_AW-1:0] rom_addr;
  logic [7:0]            rom_dati;
  logic                  rom_ce;
  logic                  rom_oe;
  logic                  rom_we;
  logic [HUC_MEM_AW-1:0] ram_addr;
  logic [7:0]            ram_dati;
  logic                  ram_ce;
  logic                  ram_oe;
  logic                  ram_we;
  logic                  cart_ce;
  logic [7:0]            cart_dato;

  modport master (
    output cpu_addr, cpu_data, cpu_oe, cpu_we, rom_dato, ram_dato,
    input  rom_addr, rom_dati, rom_ce, rom_oe, rom_we,
    input  ram_addr, ram_dati, ram_ce, ram_oe, ram_we, cart_ce, cart_dato
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_oe, cpu_we, rom_dato, ram_dato,
    output rom_addr, rom_dati, rom_ce, rom_oe, rom_we,
    output ram_addr, ram_dati, ram_ce, ram_oe, ram_we, cart_ce, cart_dato
  );

endinterface

// File: rtl/huc_bus_edge.sv
// Registers the CPU strobes and flags their rising edge, so a strobe held
// for many cycles still counts as a single bus event.
module huc_bus_edge (
  input  logic clk,
  input  logic rst,
  input  logic cpu_we,
  input  logic cpu_oe,
  output logic wr_ev,
  output logic rd_ev
);

  logic we_q;
  logic oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      we_q <= cpu_we;
      oe_q <= cpu_oe;
    end
  end

  assign wr_ev = cpu_we & ~we_q;
  assign rd_ev = cpu_oe & ~oe_q;

endmodule

// File: rtl/huc_map_ext.sv
// HuCard mapper: ROM window decode with optional SF2 banking and ROM writes,
// plus a lockable backup-RAM window and the cart data-return mux.
module huc_map_ext
  import huc_pkg::*;
#(
  parameter logic [HUC_MEM_AW-1:0] ROM_BASE  = 24'hFE0000,
  parameter int                    ROM_AW    = 17,
  parameter int                    SF2_EN    = 0,
  parameter int                    ROM_WR_EN = 0,
  parameter int                    BRAM_EN   = 1,
  parameter logic [HUC_MEM_AW-1:0] BRAM_BASE = 24'h000000,
  parameter int                    BRAM_AW   = 11
) (
  input  logic          clk,
  input  logic          rst,
  huc_map_ext_if.slave  bus,
  output logic [1:0]    bank,
  output logic          bram_unlocked
);

  localparam logic [HUC_MEM_AW-1:0] ROM_MASK   = huc_low_mask(ROM_AW);
  localparam logic [HUC_MEM_AW-1:0] BRAM_MASK  = huc_low_mask(BRAM_AW);
  localparam logic [HUC_MEM_AW-1:0] TOP8K_MASK = ROM_MASK & ~24'h001FFF;

  logic                  wr_ev;
  logic                  rd_ev;
  logic [1:0]            bank_q, bank_d;
  logic                  unl_q, unl_d;
  logic [HUC_MEM_AW-1:0] addr_ext;
  logic [HUC_MEM_AW-1:0] sf2_src;
  logic [HUC_MEM_AW-1:0] off;
  logic [2:0]            bank_page;
  logic                  sf2_hit;
  logic                  bram_hit;
  logic                  unlk_ev;
  logic                  lock_ev;
  logic                  ram_ce_w;

  huc_bus_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .cpu_we (bus.cpu_we),
    .cpu_oe (bus.cpu_oe),
    .wr_ev  (wr_ev),
    .rd_ev  (rd_ev)
  );

  // Upper half of the first MB selects one of four 512 KB banks, offset by one.
  always_comb begin
    addr_ext  = {3'b000, bus.cpu_addr};
    bank_page = {1'b0, bank_q} + 3'd1;
    if (bus.cpu_addr[19]) sf2_src = {2'b00, bank_page, bus.cpu_addr[18:0]};
    else                  sf2_src = {5'b00000, bus.cpu_addr[18:0]};
    off = ((SF2_EN != 0) ? sf2_src : addr_ext) & ROM_MASK;
  end

  assign sf2_hit  = ~bus.cpu_addr[20] & (bus.cpu_addr[12:2] == HUC_SF2_REG[12:2]);
  assign bram_hit = (bus.cpu_addr[20:11] == HUC_BRAM_PAGE[20:11]);
  assign unlk_ev  = wr_ev & (bus.cpu_addr == HUC_BRAM_UNLK) & bus.cpu_data[7];
  assign lock_ev  = rd_ev & (bus.cpu_addr == HUC_BRAM_LOCK);

  always_comb begin
    bank_d = bank_q;
    if (wr_ev && sf2_hit) bank_d = bus.cpu_addr[1:0];
    unl_d = unl_q;
    if (BRAM_EN != 0) begin
      if (lock_ev)      unl_d = 1'b0;
      else if (unlk_ev) unl_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= 2'd0;
      unl_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      unl_q  <= unl_d;
    end
  end

  assign bank          = bank_q;
  assign bram_unlocked = unl_q;

  assign bus.rom_ce   = ~bus.cpu_addr[20];
  assign bus.rom_oe   = bus.cpu_oe;
  assign bus.rom_addr = ROM_BASE | off;
  assign bus.rom_dati = bus.cpu_data;
  // Bank-register pokes land in the writable top 8 KB; they must not corrupt it.
  assign bus.rom_we   = (ROM_WR_EN != 0) && (SF2_EN == 0) && bus.rom_ce && bus.cpu_we
                        && ((off & TOP8K_MASK) == TOP8K_MASK) && !sf2_hit;

  assign ram_ce_w     = (BRAM_EN != 0) && bram_hit && unl_q;
  assign bus.ram_ce   = ram_ce_w;
  assign bus.ram_oe   = (BRAM_EN != 0) ? bus.cpu_oe : 1'b0;
  assign bus.ram_we   = bus.cpu_we & ram_ce_w;
  assign bus.ram_addr = (BRAM_EN != 0) ? (BRAM_BASE | (addr_ext & BRAM_MASK)) : '0;
  assign bus.ram_dati = (BRAM_EN != 0) ? bus.cpu_data : 8'h00;

  assign bus.cart_ce   = bus.rom_ce | ram_ce_w;
  assign bus.cart_dato = bus.rom_ce ? bus.rom_dato : bus.ram_dato;

endmodule
